plus_asic_gate: RTL and testbench

PLUS_ASIC_GATE -- requirements
Module: plus_asic_gate

---
 rtl/plus_asic_pkg.sv | 21 ++
 rtl/plus_rd_mux.sv | 41 ++++
 rtl/plus_asic_gate.sv | 114 +++++++++++
 tb/tb_plus_asic_gate.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/plus_asic_pkg.sv
// Shared types and constants for the Plus ASIC unlock gate.
package plus_asic_pkg;

  localparam int unsigned SEQ_LEN_MAX = 32;
  localparam logic [2:0]  RMR2_OP     = 3'b101;
  localparam logic [7:0]  CRTC_SEL_HI = 8'hBC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_MATCH = 2'd2
  } gate_state_e;

  // Unlock sequence; unused tail entries are zero.
  localparam logic [0:SEQ_LEN_MAX-1][7:0] ACID_SEQ = {
    8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
    8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD,
    8'hEE, 120'h0
  };

endpackage

// File: rtl/plus_rd_mux.sv
// Priority read-data mux (lowest source index wins) with registered output.
module plus_rd_mux
  import plus_asic_pkg::*;
#(
  parameter int unsigned N_SRC = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               rd,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [7:0]         data_out,
  output logic               hit
);

  logic [7:0] sel_data;
  logic       sel_hit;

  always_comb begin
    sel_data = 8'hFF;
    sel_hit  = 1'b0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (!sel_hit && src_valid[i]) begin
        sel_data = src_data[8*i +: 8];
        sel_hit  = 1'b1;
      end
    end
  end

  // Outputs only move on a read cycle; otherwise they hold.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= 8'hFF;
      hit      <= 1'b0;
    end else if (rd) begin
      data_out <= sel_data;
      hit      <= sel_hit;
    end
  end

endmodule

// File: rtl/plus_asic_gate.sv
// Plus ASIC unlock gate: CRTC-select byte sequence matcher, RMR2 page enable,
// and the CPU read-data mux.
module plus_asic_gate
  import plus_asic_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 17,
  parameter int unsigned N_SRC   = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               plus_mode,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_data_in,
  input  logic               cpu_wr,
  input  logic               cpu_rd,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [7:0]         cpu_data_out,
  output logic               rd_hit,
  output logic               unlocked,
  output logic               unlock_pulse,
  output logic               asic_page_en,
  output logic [4:0]         seq_idx
);

  localparam logic [4:0] LAST_IDX = 5'(SEQ_LEN - 1);

  gate_state_e state;
  logic        cpu_wr_q;
  logic        wr_event;
  logic        crtc_wr;
  logic        rmr2_wr;
  logic        byte_ok;
  logic        byte_zero;
  logic        unused_addr_lo;

  assign unused_addr_lo = ^cpu_addr[7:0];

  assign wr_event  = cpu_wr & ~cpu_wr_q;
  assign crtc_wr   = wr_event && (cpu_addr[15:8] == CRTC_SEL_HI);
  assign rmr2_wr   = wr_event && (cpu_addr[15:14] == 2'b01) && (cpu_data_in[7:5] == RMR2_OP);
  assign byte_ok   = (cpu_data_in == ACID_SEQ[seq_idx]);
  assign byte_zero = (cpu_data_in == 8'h00);

  // Sequence matcher and lock/page state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      seq_idx      <= 5'd0;
      unlocked     <= 1'b0;
      unlock_pulse <= 1'b0;
      asic_page_en <= 1'b0;
      cpu_wr_q     <= 1'b0;
    end else begin
      cpu_wr_q     <= cpu_wr;
      unlock_pulse <= 1'b0;
      if (!plus_mode) begin
        state        <= ST_IDLE;
        seq_idx      <= 5'd0;
        unlocked     <= 1'b0;
        asic_page_en <= 1'b0;
      end else begin
        if (crtc_wr) begin
          case (state)
            ST_IDLE: begin
              if (!byte_zero) state <= ST_SYNC;
            end
            ST_SYNC: begin
              // The zero byte completes SEQ[0], SEQ[1].
              if (byte_zero) begin
                state   <= ST_MATCH;
                seq_idx <= 5'd2;
              end
            end
            ST_MATCH: begin
              if (seq_idx == LAST_IDX) begin
                state   <= ST_IDLE;
                seq_idx <= 5'd0;
                if (byte_ok) begin
                  unlocked     <= 1'b1;
                  unlock_pulse <= ~unlocked;
                end else begin
                  unlocked     <= 1'b0;
                  asic_page_en <= 1'b0;
                end
              end else if (byte_ok) begin
                seq_idx <= seq_idx + 5'd1;
              end else begin
                seq_idx <= 5'd0;
                state   <= byte_zero ? ST_IDLE : ST_SYNC;
              end
            end
            default: begin
              state   <= ST_IDLE;
              seq_idx <= 5'd0;
            end
          endcase
        end
        if (rmr2_wr) asic_page_en <= unlocked & (cpu_data_in[4:3] == 2'b11);
      end
    end
  end

  plus_rd_mux #(.N_SRC(N_SRC)) u_rd_mux (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .rd        (cpu_rd),
    .src_valid (src_valid),
    .src_data  (src_data),
    .data_out  (cpu_data_out),
    .hit       (rd_hit)
  );

endmodule

// File: tb/tb_plus_asic_gate.sv
// Directed self-checking bench for plus_asic_gate.
module tb_plus_asic_gate;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        plus_mode;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [7:0]  cpu_data_out;
  logic        rd_hit;
  logic        unlocked;
  logic        unlock_pulse;
  logic        asic_page_en;
  logic [4:0]  seq_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  logic [7:0] acid [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
                            8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD,
                            8'hEE};

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (unlock_pulse === 1'b1) pulse_cnt++;

  plus_asic_gate #(.SEQ_LEN(17), .N_SRC(4)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .plus_mode    (plus_mode),
    .cpu_addr     (cpu_addr),
    .cpu_data_in  (cpu_data_in),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .cpu_data_out (cpu_data_out),
    .rd_hit       (rd_hit),
    .unlocked     (unlocked),
    .unlock_pulse (unlock_pulse),
    .asic_page_en (asic_page_en),
    .seq_idx      (seq_idx)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk_sys);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_wr      = 1'b1;
    repeat (hold) @(negedge clk_sys);
    cpu_wr = 1'b0;
  endtask

  task automatic send_seq(input int first, input int last, input int hold);
    for (int i = first; i <= last; i++) wr_byte(16'hBC00, acid[i], hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_unlocked"}, 16'(unlocked), 16'd0);
    check({tag, "_pulse"},    16'(unlock_pulse), 16'd0);
    check({tag, "_page"},     16'(asic_page_en), 16'd0);
    check({tag, "_data"},     16'(cpu_data_out), 16'h00FF);
    check({tag, "_hit"},      16'(rd_hit), 16'd0);
    check({tag, "_idx"},      16'(seq_idx), 16'd0);
  endtask

  initial begin
    int pc;
    reset_n = 1'b0; plus_mode = 1'b1; cpu_addr = '0; cpu_data_in = '0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; src_valid = '0;
    src_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Full sequence with single-cycle strobes
    send_seq(0, 0, 1);
    check("idle_to_sync_idx", 16'(seq_idx), 16'd0);
    send_seq(1, 1, 1);
    check("sync_to_match_idx", 16'(seq_idx), 16'd2);
    send_seq(2, 15, 1);
    check("pre_last_idx", 16'(seq_idx), 16'd16);
    check("pre_last_locked", 16'(unlocked), 16'd0);
    send_seq(16, 16, 1);
    check("unlock_pulse_hi", 16'(unlock_pulse), 16'd1);
    check("unlocked_set", 16'(unlocked), 16'd1);
    check("idx_back_zero", 16'(seq_idx), 16'd0);
    @(negedge clk_sys);
    check("unlock_pulse_lo", 16'(unlock_pulse), 16'd0);
    check("pulse_count_1", 16'(pulse_cnt), 16'd1);

    // RMR2 page enable while unlocked
    wr_byte(16'h7F00, 8'hB8, 1);
    check("rmr2_page_on", 16'(asic_page_en), 16'd1);
    wr_byte(16'h7F00, 8'hA0, 1);
    check("rmr2_page_off", 16'(asic_page_en), 16'd0);
    wr_byte(16'h7F00, 8'hB8, 1);
    check("rmr2_page_on2", 16'(asic_page_en), 16'd1);

    // Re-unlock while unlocked: no pulse
    pc = pulse_cnt;
    send_seq(0, 16, 1);
    @(negedge clk_sys);
    check("reunlock_state", 16'(unlocked), 16'd1);
    check("reunlock_no_pulse", 16'(pulse_cnt - pc), 16'd0);

    // Bad final byte relocks and clears the page
    pc = pulse_cnt;
    send_seq(0, 15, 1);
    wr_byte(16'hBC00, 8'h00, 1);
    check("relock_unlocked", 16'(unlocked), 16'd0);
    check("relock_page", 16'(asic_page_en), 16'd0);
    @(negedge clk_sys);
    check("relock_no_pulse", 16'(pulse_cnt - pc), 16'd0);
    wr_byte(16'h7F00, 8'hB8, 1);
    check("rmr2_locked_page", 16'(asic_page_en), 16'd0);

    // Zero-byte mismatch returns to IDLE, where a further zero stays put
    send_seq(0, 2, 1);
    wr_byte(16'hBC00, 8'h00, 1);
    check("mismatch_zero_idx", 16'(seq_idx), 16'd0);
    wr_byte(16'hBC00, 8'h00, 1);
    check("idle_zero_stays", 16'(seq_idx), 16'd0);

    // Mismatch at index 5 then resync from index 2
    pc = pulse_cnt;
    send_seq(0, 4, 1);
    check("mm_pre_idx", 16'(seq_idx), 16'd5);
    wr_byte(16'hBC00, 8'h33, 1);
    check("mm_to_sync_idx", 16'(seq_idx), 16'd0);
    wr_byte(16'hBC00, 8'h00, 1);
    check("mm_resync_idx", 16'(seq_idx), 16'd2);
    send_seq(2, 16, 1);
    @(negedge clk_sys);
    check("mm_unlocked", 16'(unlocked), 16'd1);
    check("mm_pulse", 16'(pulse_cnt - pc), 16'd1);

    // Read mux
    @(negedge clk_sys);
    cpu_rd = 1'b1; src_valid = 4'b0110;
    @(negedge clk_sys);
    cpu_rd = 1'b0;
    check("rd_prio_data", 16'(cpu_data_out), 16'h0022);
    check("rd_prio_hit", 16'(rd_hit), 16'd1);
    src_valid = 4'b0001;
    @(negedge clk_sys);
    check("rd_hold_data", 16'(cpu_data_out), 16'h0022);
    cpu_rd = 1'b1; src_valid = 4'b0000;
    @(negedge clk_sys);
    cpu_rd = 1'b0;
    check("rd_none_data", 16'(cpu_data_out), 16'h00FF);
    check("rd_none_hit", 16'(rd_hit), 16'd0);

    // Read and CRTC write in the same cycle
    cpu_rd = 1'b1; src_valid = 4'b1000;
    cpu_addr = 16'hBC00; cpu_data_in = 8'hFF; cpu_wr = 1'b1;
    @(negedge clk_sys);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    check("simul_rd_data", 16'(cpu_data_out), 16'h0044);
    check("simul_rd_hit", 16'(rd_hit), 16'd1);
    wr_byte(16'hBC00, 8'h00, 1);
    check("simul_wr_idx", 16'(seq_idx), 16'd2);

    // plus_mode low forces lock and IDLE
    wr_byte(16'h7F00, 8'hB8, 1);
    check("pm_page_pre", 16'(asic_page_en), 16'd1);
    @(negedge clk_sys);
    plus_mode = 1'b0;
    @(negedge clk_sys);
    check("pm_unlocked", 16'(unlocked), 16'd0);
    check("pm_page", 16'(asic_page_en), 16'd0);
    check("pm_idx", 16'(seq_idx), 16'd0);
    plus_mode = 1'b1;

    // Held strobes advance once per byte; reset mid-sequence
    for (int i = 0; i <= 9; i++) begin
      wr_byte(16'hBC00, acid[i], 5);
      check($sformatf("held_idx_%0d", i), 16'(seq_idx), (i == 0) ? 16'd0 : 16'(i + 1));
    end
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    send_seq(10, 16, 5);
    check("post_rst_locked", 16'(unlocked), 16'd0);
    check("post_rst_idx", 16'(seq_idx), 16'd0);
    pc = pulse_cnt;
    send_seq(0, 16, 5);
    @(negedge clk_sys);
    check("held_unlock", 16'(unlocked), 16'd1);
    check("held_pulse", 16'(pulse_cnt - pc), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
